// File: rtl/lif_neuron_array.sv
`default_nettype none
// ============================================================================
// Module   : lif_neuron_array
// Purpose  : Time-multiplexed bank of leaky integrate-and-fire neurons that
//            share one read-modify-write update datapath. Each accepted sample
//            updates one addressed neuron, and spikes leave as indexed events.
// Config   : LIF_REFRACTORY_EN adds a per-neuron refractory counter.
// Revision : 1.0 - initial release
// ============================================================================
module lif_neuron_array #(
    parameter int N_NEURONS  = 16,
    parameter int IDX_W      = 4,
    parameter int IN_W       = 8,
    parameter int POT_W      = 12,
    parameter int LEAK_SHIFT = 1,
    parameter int REFRACT    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic [POT_W-1:0] i_threshold,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [IDX_W-1:0] i_in_idx,
    input  logic [IN_W-1:0]  i_in_current,
    output logic             o_spike_valid,
    output logic [IDX_W-1:0] o_spike_idx,
    output logic [15:0]      o_spike_count
);

    localparam logic [0:0]       ST_RUN    = 1'b0;
    localparam logic [0:0]       ST_CLEAR  = 1'b1;
    localparam logic [IDX_W-1:0] c_last    = IDX_W'(N_NEURONS - 1);
    localparam logic [15:0]      c_cnt_max = 16'hFFFF;

    logic [0:0]       r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [POT_W-1:0] r_pot [N_NEURONS];
    logic             r_spike_valid;
    logic [IDX_W-1:0] r_spike_idx;
    logic [15:0]      r_spike_count;

    logic             w_accept;
    logic             w_idx_ok;
    logic             w_refr_busy;
    logic             w_do_update;
    logic             w_fire;
    logic [POT_W-1:0] w_pot_cur;
    logic [POT_W-1:0] w_leaked;
    logic [POT_W:0]   w_sum;
    logic [POT_W-1:0] w_next_pot;

    assign o_in_ready = (r_state == ST_RUN) && !i_clear;
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_idx_ok   = (32'(i_in_idx) < 32'(N_NEURONS));

    // Stored potential is read combinationally, so a back-to-back sample to
    // the same neuron always sees the value written on the previous edge.
    assign w_pot_cur   = r_pot[i_in_idx];
    assign w_leaked    = w_pot_cur >> LEAK_SHIFT;
    assign w_sum       = {1'b0, w_leaked} + (POT_W + 1)'(i_in_current);
    assign w_next_pot  = w_sum[POT_W] ? {POT_W{1'b1}} : w_sum[POT_W-1:0];
    assign w_do_update = w_accept && w_idx_ok && !w_refr_busy;
    // Firing looks at the potential before this sample; its current is dropped.
    assign w_fire      = (w_pot_cur >= i_threshold);

`ifdef LIF_REFRACTORY_EN
    localparam int         c_refr_w    = $clog2(REFRACT + 1);
    localparam logic [c_refr_w-1:0] c_refr_load = c_refr_w'(REFRACT);

    logic [c_refr_w-1:0] r_refr [N_NEURONS];

    assign w_refr_busy = (r_refr[i_in_idx] != '0);

    // Refractory counters: loaded on a spike, count down only on samples
    // addressed to their own neuron, wiped by the clear sweep.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_NEURONS; k++) begin
                r_refr[k] <= '0;
            end
        end else if (r_state == ST_CLEAR) begin
            r_refr[r_ptr] <= '0;
        end else if (w_accept && w_idx_ok) begin
            if (w_refr_busy) begin
                r_refr[i_in_idx] <= r_refr[i_in_idx] - 1'b1;
            end else if (w_fire) begin
                r_refr[i_in_idx] <= c_refr_load;
            end
        end
    end
`else
    // Without counters a neuron is never busy; a negative length cannot occur.
    assign w_refr_busy = (REFRACT < 0);
`endif

    // Potential array: zeroed one entry per cycle while sweeping, otherwise
    // updated for the addressed neuron (reset on fire, leak+integrate if not).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_NEURONS; k++) begin
                r_pot[k] <= '0;
            end
        end else if (r_state == ST_CLEAR) begin
            r_pot[r_ptr] <= '0;
        end else if (w_do_update) begin
            r_pot[i_in_idx] <= w_fire ? '0 : w_next_pot;
        end
    end

    // Control: run/clear sequencing, registered spike event and saturating count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_ptr         <= '0;
            r_spike_valid <= 1'b0;
            r_spike_idx   <= '0;
            r_spike_count <= '0;
        end else begin
            r_spike_valid <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (i_clear) begin
                        r_state       <= ST_CLEAR;
                        r_ptr         <= '0;
                        r_spike_count <= '0;
                    end else if (w_do_update && w_fire) begin
                        r_spike_valid <= 1'b1;
                        r_spike_idx   <= i_in_idx;
                        if (r_spike_count != c_cnt_max) begin
                            r_spike_count <= r_spike_count + 16'd1;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (r_ptr == c_last) begin
                        r_state <= ST_RUN;
                    end
                    r_ptr <= r_ptr + 1'b1;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign o_spike_valid = r_spike_valid;
    assign o_spike_idx   = r_spike_idx;
    assign o_spike_count = r_spike_count;

endmodule
`default_nettype wire
